// File: rtl/block_ram_arbiter.sv
// block_ram_arbiter: shares one block RAM between the UART host (port 0) and the skein engine (port 1).
// Burst-limited round-robin by default; define BLOCK_RAM_ARB_FIXED_PRIORITY_EN to make port 0 always win.
module block_ram_arbiter #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 16,
    parameter int RAM_LATENCY = 1,
    parameter int MAX_BURST   = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              req0_i,
    input  logic              req1_i,
    input  logic              we0_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic              gnt0_o,
    output logic              gnt1_o,
    output logic              rvalid0_o,
    output logic              rvalid1_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic [ADDR_W-1:0] ram_address_o,
    output logic [DATA_W-1:0] ram_data_o,
    input  logic [DATA_W-1:0] ram_data_i,
    output logic              ram_write_o
);
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t               state;
    logic                 last_owner;
    logic [CNT_W-1:0]     burst_cnt;
    logic [RAM_LATENCY-1:0] tag_vld;
    logic [RAM_LATENCY-1:0] tag_port;
    logic                 win_vld;
    logic                 win_port;
    logic                 other_req;
    logic                 stay;
    logic [CNT_W-1:0]     next_cnt;

    always_comb begin
        win_vld   = req0_i || req1_i;
`ifdef BLOCK_RAM_ARB_FIXED_PRIORITY_EN
        win_port  = !req0_i;
`else
        // In OWNk last_owner is k, so a contested grant stays with it until the burst limit.
        win_port  = (req0_i && req1_i) ?
                    ((state == IDLE || burst_cnt >= MAX_CNT) ? !last_owner : last_owner) :
                    req1_i;
`endif
        other_req = win_port ? req0_i : req1_i;
        stay      = (state != IDLE) && (win_port == last_owner);
        next_cnt  = (stay && other_req) ?
                    ((burst_cnt >= MAX_CNT) ? MAX_CNT : burst_cnt + CNT_W'(1)) :
                    CNT_W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state         <= IDLE;
            last_owner    <= 1'b1;
            burst_cnt     <= '0;
            gnt0_o        <= 1'b0;
            gnt1_o        <= 1'b0;
            ram_write_o   <= 1'b0;
            ram_address_o <= '0;
            ram_data_o    <= '0;
            tag_vld       <= '0;
            tag_port      <= '0;
            rvalid0_o     <= 1'b0;
            rvalid1_o     <= 1'b0;
            rdata_o       <= '0;
        end else begin
            gnt0_o      <= win_vld && !win_port;
            gnt1_o      <= win_vld && win_port;
            ram_write_o <= win_vld && (win_port ? we1_i : we0_i);
            if (win_vld) begin
                ram_address_o <= win_port ? addr1_i : addr0_i;
                ram_data_o    <= win_port ? wdata1_i : wdata0_i;
                state         <= win_port ? OWN1 : OWN0;
                last_owner    <= win_port;
                burst_cnt     <= next_cnt;
            end else begin
                state     <= IDLE;
                burst_cnt <= '0;
            end
            // Tags enter from the registered grant, giving RAM_LATENCY+1 clocks grant-to-rvalid.
            tag_vld[0]  <= (gnt0_o || gnt1_o) && !ram_write_o;
            tag_port[0] <= gnt1_o;
            for (int i = 1; i < RAM_LATENCY; i++) begin
                tag_vld[i]  <= tag_vld[i-1];
                tag_port[i] <= tag_port[i-1];
            end
            rvalid0_o <= tag_vld[RAM_LATENCY-1] && !tag_port[RAM_LATENCY-1];
            rvalid1_o <= tag_vld[RAM_LATENCY-1] && tag_port[RAM_LATENCY-1];
            if (tag_vld[RAM_LATENCY-1])
                rdata_o <= ram_data_i;
        end
    end
endmodule
